lcd_panel_reset_seq: RTL

LCD_PANEL_RESET_SEQ -- requirements
Module: lcd_panel_reset_seq

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_rst_sync.sv | 34 +++
 rtl/lcd_panel_reset_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD panel reset sequencer: state encoding and timing defaults.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

  // Default timing, in i_clk cycles.
  localparam int unsigned LCD_T_RST_LOW_DEF = 1000;
  localparam int unsigned LCD_T_RECOVER_DEF = 12000;
  // Must satisfy 2**width > max(T_RST_LOW, T_RECOVER).
  localparam int unsigned LCD_CNT_W_DEF     = 16;

  // State encoding.
  localparam logic [1:0] LCD_ENC_SYNC    = 2'd0;
  localparam logic [1:0] LCD_ENC_HOLD    = 2'd1;
  localparam logic [1:0] LCD_ENC_RECOVER = 2'd2;
  localparam logic [1:0] LCD_ENC_READY   = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC    = LCD_ENC_SYNC,
    ST_HOLD    = LCD_ENC_HOLD,
    ST_RECOVER = LCD_ENC_RECOVER,
    ST_READY   = LCD_ENC_READY
  } lcd_state_e;

  // Saturating 8-bit increment used for the completed-sequence counter.
  function automatic logic [7:0] lcd_sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lcd_rst_sync.sv
// Reset synchronizer: asserts o_rst asynchronously, releases it synchronously to i_clk.
// Latency: release seen on the 2nd rising i_clk edge after i_rst falls; assertion is immediate.
// Backpressure: none.
module lcd_rst_sync (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_rst
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic meta_d;
  logic sync_d;

  // Shift a deasserted level through the two-stage chain.
  always_comb begin
    meta_d = 1'b0;
    sync_d = meta_q;
  end

  // Both stages preset while the raw reset is high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_rst = sync_q;

endmodule

// File: rtl/lcd_panel_reset_seq.sv
// Panel reset sequencer: drives the panel reset pin low for P_T_RST_LOW, then waits P_T_RECOVER before READY.
// Latency: all outputs registered; a soft request in READY pulls the pin low one cycle after it is sampled.
// Backpressure: none; soft requests outside READY are dropped, and a held request counts once.
module lcd_panel_reset_seq
  import lcd_pkg::*;
#(
  parameter int unsigned P_T_RST_LOW = LCD_T_RST_LOW_DEF,
  parameter int unsigned P_T_RECOVER = LCD_T_RECOVER_DEF,
  parameter int unsigned P_CNT_W     = LCD_CNT_W_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_soft_req,
  output logic       o_lcd_rst_n,
  output logic       o_busy,
  output logic       o_ready,
  output logic       o_done,
  output logic [7:0] o_seq_cnt
);

  // Counter reload values: a state lasts (reload + 1) cycles and exits when the counter reads 0.
  localparam logic [P_CNT_W-1:0] CNT_HOLD = P_CNT_W'(P_T_RST_LOW - 1);
  localparam logic [P_CNT_W-1:0] CNT_REC  = P_CNT_W'(P_T_RECOVER - 1);
  localparam logic [P_CNT_W-1:0] CNT_ONE  = P_CNT_W'(1);

  logic               rst_sync;
  lcd_state_e         state_q, state_d;
  logic [P_CNT_W-1:0] cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               lcd_rst_n_q, lcd_rst_n_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [7:0]         seq_cnt_q, seq_cnt_d;
  logic               req_rise;

  lcd_rst_sync u_rst_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .o_rst (rst_sync)
  );

  // A request held high across a whole sequence must not re-trigger, so only the rising edge counts.
  assign req_rise = i_soft_req & ~req_q;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = i_soft_req;

    case (state_q)
      ST_SYNC: begin
        cnt_d = '0;
        if (!rst_sync) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RECOVER;
          cnt_d   = CNT_REC;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (cnt_q == '0) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_READY: begin
        cnt_d = '0;
        if (req_rise) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_HOLD;
        end
      end
      default: begin
        state_d = ST_SYNC;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    lcd_rst_n_d = (state_d == ST_RECOVER) || (state_d == ST_READY);
    busy_d      = (state_d != ST_READY);
    ready_d     = (state_d == ST_READY);
    done_d      = (state_d == ST_READY) && (state_q != ST_READY);
    seq_cnt_d   = done_d ? lcd_sat_inc8(seq_cnt_q) : seq_cnt_q;
  end

  // State, counter and output registers; raw reset forces the safe (panel-held) state at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_SYNC;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      lcd_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      seq_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      lcd_rst_n_q <= lcd_rst_n_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      seq_cnt_q   <= seq_cnt_d;
    end
  end

  assign o_lcd_rst_n = lcd_rst_n_q;
  assign o_busy      = busy_q;
  assign o_ready     = ready_q;
  assign o_done      = done_q;
  assign o_seq_cnt   = seq_cnt_q;

endmodule
